// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the radix-2 Booth multiplier.
package mult_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/cla_adder32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla_adder32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        c_in,
    output logic [31:0] s
);

    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  gc;

    assign g     = x & y;
    assign p     = x ^ y;
    assign gc[0] = c_in;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        logic [3:0] c;

        assign c[0] = gc[k];
        assign c[1] = g[B] | (p[B] & gc[k]);
        assign c[2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[k]);
        assign s[B+3:B] = p[B+3:B] ^ c;

        // The top group's carry-out is dropped: the sum wraps at 32 bits.
        if (k < 7) begin : g_cout
            assign gc[k+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                           | (p[B+3] & p[B+2] & p[B+1] & g[B]) | ((&p[B+3:B]) & gc[k]);
        end
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth multiplier, one iteration per cycle through a shared CLA adder.
// Optional signed-overflow flag enabled by defining MULT_EXCEPTION_EN.
module booth_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             data_ready,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, a_q;
    logic             qm1_q;
    logic [WIDTH-1:0] add_y, sum, acc;
    logic             add_cin;
    logic             accept;

    assign accept = start && (state_q != StRun);

    // Subtract via two's complement: invert A and carry in one.
    always_comb begin
        add_y   = a_q;
        add_cin = 1'b0;
        if (lo_q[0] && !qm1_q) begin
            add_y   = ~a_q;
            add_cin = 1'b1;
        end
    end

    cla_adder32 u_adder (
        .x    (hi_q),
        .y    (add_y),
        .c_in (add_cin),
        .s    (sum)
    );

    assign acc = (lo_q[0] ^ qm1_q) ? sum : hi_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qm1_q   <= 1'b0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                hi_q  <= '0;
                lo_q  <= multiplier;
                qm1_q <= 1'b0;
                a_q   <= multiplicand;
                cnt_q <= '0;
            end else if (state_q == StRun) begin
                hi_q  <= {acc[WIDTH-1], acc[WIDTH-1:1]};
                lo_q  <= {acc[0], lo_q[WIDTH-1:1]};
                qm1_q <= lo_q[0];
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign busy       = (state_q == StRun);
    assign data_ready = (state_q == StDone);
    assign result     = lo_q;

`ifdef MULT_EXCEPTION_EN
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
    logic amin_ovf_q;

    // The 32-bit accumulator wraps when A is the most negative value, so hi is
    // unreliable there; that case overflows unless B is 0 or 1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            amin_ovf_q <= 1'b0;
        end else if (accept) begin
            amin_ovf_q <= (multiplier[WIDTH-1:1] != '0);
        end
    end

    assign exception = (state_q != StRun) &&
                       ((a_q == MinVal) ? amin_ovf_q : (hi_q != {WIDTH{lo_q[WIDTH-1]}}));
`else
    assign exception = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl: directed cases plus random traffic
// compared every cycle against a cycle-count/arithmetic reference model.
module tb_booth_mult_ctrl;

`ifdef MULT_EXCEPTION_EN
    localparam bit ExcOn = 1'b1;
`else
    localparam bit ExcOn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        data_ready;
    logic [31:0] result;
    logic        exception;

    int checks   = 0;
    int failures = 0;

    booth_mult_ctrl #(.WIDTH(32)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .data_ready   (data_ready),
        .result       (result),
        .exception    (exception)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] full_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    function automatic logic model_exc(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = full_prod(a, b);
        return ExcOn && (p[63:32] != {32{p[31]}});
    endfunction

    // Reference model: edges elapsed since the last accepted start (-1: none).
    int          m_since;
    logic [31:0] m_res;
    logic        m_exc;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_since <= -1;
            m_res   <= '0;
            m_exc   <= 1'b0;
        end else if (start && !(m_since >= 0 && m_since < 32)) begin
            m_since <= 0;
            m_res   <= full_prod(multiplicand, multiplier) & 64'hFFFF_FFFF;
            m_exc   <= model_exc(multiplicand, multiplier);
        end else if (m_since >= 0 && m_since < 1000) begin
            m_since <= m_since + 1;
        end
    end

    always @(negedge clock) begin
        check("busy", {31'b0, busy}, {31'b0, (m_since >= 0 && m_since < 32)});
        check("data_ready", {31'b0, data_ready}, {31'b0, (m_since == 32)});
        if (m_since < 0 || m_since >= 32) begin
            check("result", result, m_res);
            check("exception", {31'b0, exception}, {31'b0, m_exc});
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                     32'h7FFF_FFFF, 32'h0000_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
    endtask

    // Expects start already driven for the coming accept edge; counts cycles
    // after that edge until data_ready. A start pulse is injected at cycle intrude.
    task automatic finish_op(input string name, input logic [31:0] lit_res,
                             input logic lit_exc, input int intrude);
        int n;
        @(negedge clock);
        n = 1;
        while (!data_ready && n < 40) begin
            if (n == intrude) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end else begin
                start        = 1'b0;
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(n), 32'd33);
        check({name, "_result"}, result, lit_res);
        check({name, "_exc"}, {31'b0, exception}, {31'b0, lit_exc});
    endtask

    initial begin
        resetn       = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        resetn = 1'b1;

        launch(32'd3, 32'd5);
        finish_op("3x5", 32'h0000_000F, 1'b0, 0);
        launch(32'hFFFF_FFF9, 32'd6);
        finish_op("m7x6", 32'hFFFF_FFD6, 1'b0, 0);
        launch(32'h7FFF_FFFF, 32'd2);
        finish_op("max_x2", 32'hFFFF_FFFE, ExcOn, 0);
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("min_xm1", 32'h8000_0000, ExcOn, 0);
        launch(32'd2, 32'd2);
        finish_op("ignore_start", 32'h0000_0004, 1'b0, 10);

        // Reset in the middle of a run, then restart on the release edge.
        launch(32'd5, 32'd7);
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_dr", {31'b0, data_ready}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_exc", {31'b0, exception}, 32'd0);
        @(negedge clock);
        resetn       = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd4;
        multiplier   = 32'd4;
        finish_op("rst_4x4", 32'h0000_0010, 1'b0, 0);

        // Random traffic, including back-to-back starts in DONE.
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            start        = ($urandom_range(0, 2) == 0);
            multiplicand = pick();
            multiplier   = pick();
        end
        @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mult_ctrl.md
BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply, sampled on rising edge.
REQ-005 SHALL have port multiplicand  input  32  signed operand A, sampled with start.
REQ-006 SHALL have port multiplier  input  32  signed operand B, sampled with start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port data_ready  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port result  output  32  low 32 bits of signed A*B.
REQ-010 SHALL have port exception  output  1  signed 32-bit overflow of the product.

Function
REQ-011 SHALL implement radix-2 Booth multiply with 65-bit product register {hi[31:0], lo[31:0], q_m1}, one iteration per cycle, through one shared 32-bit adder.
REQ-012 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after iteration 31; DONE->RUN on start, else DONE->IDLE.
REQ-013 SHALL, on accepting start, load hi=0, lo=multiplier, q_m1=0, latch multiplicand, clear iteration counter (5 bits).
REQ-014 SHALL, per RUN cycle, select by {lo[0],q_m1}: 01 hi+A, 10 hi-A (invert A, carry-in 1), 00/11 hi unchanged; then arithmetic-shift the 65-bit register right by one.
REQ-015 SHALL ignore adder carry-out; the sum wraps at 32 bits before the shift.
REQ-016 SHALL assert data_ready for exactly the one cycle in DONE, 33 cycles after the start-accept edge.
REQ-017 SHALL drive result=lo and hold result/exception stable from DONE until the next start is accepted.
REQ-018 SHALL ignore start while in RUN; the operation and latched operands are unaffected.
REQ-019 SHALL accept start in DONE (back-to-back), data_ready still pulsing that cycle.
REQ-020 SHALL drive busy=1 exactly in RUN.

Reset
REQ-021 SHALL, on resetn low at any time including mid-RUN, asynchronously force state IDLE, counter 0, product register 0, busy 0, data_ready 0, result 0, exception 0.
REQ-022 SHALL leave resetn deassertion edge-safe: first start accepted on the first rising edge with resetn high.

Configuration
REQ-023 SHALL, with MULT_EXCEPTION_EN defined, set exception in DONE when hi is not all equal to lo[31] (64-bit product exceeds signed 32 bits).
REQ-024 SHALL, without MULT_EXCEPTION_EN, tie exception to 0 and omit its logic.

Structure
REQ-025 SHALL place WIDTH, ITER_COUNT (32), counter width (5) and the FSM state encoding in shared package mult_pkg.
REQ-026 SHALL instantiate one sub-module cla_adder32 (32-bit carry-lookahead adder, x, y, c_in -> s) as the shared adder.

Verification
REQ-027 SHALL cover: A=3, B=5 -> data_ready 33 cycles after start, result 0x0000000F, exception 0.
REQ-028 SHALL cover: A=-7, B=6 -> result 0xFFFFFFD6 (-42), exception 0.
REQ-029 SHALL cover: A=0x7FFFFFFF, B=2 -> result 0xFFFFFFFE, exception 1 (0 when MULT_EXCEPTION_EN undefined).
REQ-030 SHALL cover: A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-031 SHALL cover: start with A=2, B=2, then start with A=9, B=9 at cycle 10 -> ignored, result 0x00000004 at cycle 33.
REQ-032 SHALL cover: resetn low at RUN cycle 15 -> busy/data_ready/result 0 immediately; new start A=4, B=4 -> result 0x00000010 after 33 cycles.
